// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue constants: nop encoding and default depth.
// Decode, controller and hazard logic all agree on these values.
package fetch_queue_pkg;
    localparam int          FQ_DEPTH  = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch buffer between fetch and decode: in-order {instr, pcplus4}, dropped on flush.
// Latency: an entry written in cycle N is visible at deq_* in cycle N+1; no enq->deq bypass.
// Backpressure: enq_ready = ~full from registered count only; deq_ready is ignored while empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [WIDTH-1:0]         enq_instr,
    input  logic [WIDTH-1:0]         enq_pcplus4,
    output logic                     enq_ready,
    input  logic                     deq_ready,
    output logic                     deq_valid,
    output logic [WIDTH-1:0]         deq_instr,
    output logic [WIDTH-1:0]         deq_pcplus4,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] memInstr [DEPTH];
    logic [WIDTH-1:0] memPc    [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [CW-1:0]    countQ;
    logic             full;
    logic             empty;
    logic             enqFire;
    logic             deqFire;

    assign full    = (countQ == CW'(DEPTH));
    assign empty   = (countQ == '0);
    assign enqFire = enq_valid & ~full & ~flush;
    assign deqFire = ~empty & deq_ready & ~flush;

    assign enq_ready   = ~full;
    assign deq_valid   = ~empty;
    assign count       = countQ;
    assign deq_instr   = empty ? WIDTH'(NOP_INSTR) : memInstr[rdPtr];
    assign deq_pcplus4 = empty ? '0 : memPc[rdPtr];

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (enqFire && !reset) begin
            memInstr[wrPtr] <= enq_instr;
            memPc[wrPtr]    <= enq_pcplus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else begin
            if (enqFire) wrPtr <= wrPtr + PW'(1);
            if (deqFire) rdPtr <= rdPtr + PW'(1);
            case ({enqFire, deqFire})
                2'b10:   countQ <= countQ + CW'(1);
                2'b01:   countQ <= countQ - CW'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(enqFire && full));
    assert property (@(posedge clk) disable iff (reset) !(deqFire && empty));
endmodule
